sniff_feed_arbiter: RTL and testbench

SNIFF_FEED_ARBITER -- requirements
Module: sniff_feed_arbiter

---
 rtl/sniff_pkg.sv | 7 +
 rtl/sniff_replay_buf.sv | 36 +++
 rtl/sniff_feed_arbiter.sv | 125 ++++++++++++
 tb/tb_sniff_feed_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sniff_pkg.sv
// sniff_pkg: shared FSM state type and default widths for the sniff feed arbiter
package sniff_pkg;
  localparam int DATAWIDTH_DEF = 32;
  localparam int BUF_DEPTH_DEF = 64;
  localparam int LENW_DEF = 7;
  typedef enum logic [1:0] {IDLE, LIVE, REPLAY} state_t;
endpackage

// File: rtl/sniff_replay_buf.sv
// sniff_replay_buf: replay word store with auto-incrementing write pointer and async read
// Ports: clk, n_rst (async active-low); wr_i write strobe, clr_i pointer clear,
// wdata_i write word; raddr_i read address, rdata_o combinational read word.
module sniff_replay_buf
  import sniff_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  localparam int AW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 wr_i,
  input  logic                 clr_i,
  input  logic [DATAWIDTH-1:0] wdata_i,
  input  logic [AW-1:0]        raddr_i,
  output logic [DATAWIDTH-1:0] rdata_o
);
  logic [DATAWIDTH-1:0] mem_q [BUF_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, waddr;

  // A clear coinciding with a write lands the word at 0 and leaves the pointer at 1
  always_comb begin
    waddr = clr_i ? '0 : wr_ptr_q;
    wr_ptr_d = wr_i ? (waddr == AW'(BUF_DEPTH - 1) ? '0 : waddr + AW'(1)) : clr_i ? '0 : wr_ptr_q;
  end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) wr_ptr_q <= '0;
    else wr_ptr_q <= wr_ptr_d;

  always_ff @(posedge clk)
    if (wr_i) mem_q[waddr] <= wdata_i;

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sniff_feed_arbiter.sv
// sniff_feed_arbiter: muxes live MAC traffic and buffered replay packets onto one stream
// Ports: clk, n_rst (async active-low); live_en gates live traffic; buf_clr/buf_wr/buf_wdata
// load the replay buffer; replay_start/replay_len request a replay; mac_* is the live sink,
// out_* the source to the sniffer; busy, replay_done pulse, sticky wr_err, drop_cnt status.
module sniff_feed_arbiter
  import sniff_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int LENW = LENW_DEF
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 live_en,
  input  logic                 buf_clr,
  input  logic                 buf_wr,
  input  logic [DATAWIDTH-1:0] buf_wdata,
  input  logic                 replay_start,
  input  logic [LENW-1:0]      replay_len,
  input  logic [DATAWIDTH-1:0] mac_data,
  input  logic                 mac_valid,
  input  logic                 mac_sop,
  input  logic                 mac_eop,
  output logic                 mac_ready,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_sop,
  output logic                 out_eop,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 replay_done,
  output logic                 wr_err,
  output logic [15:0]          drop_cnt
);
  localparam int AW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;

  state_t state_q, state_d;
  logic pending_q, pending_d, wr_err_q, wr_err_d, done_q, done_d;
  logic [LENW-1:0] len_q, len_d, rd_ptr_q, rd_ptr_d;
  logic [15:0] drop_q, drop_d;
  logic [DATAWIDTH-1:0] rdata;
  logic in_replay, last;

  assign in_replay = state_q == REPLAY;

  sniff_replay_buf #(.DATAWIDTH(DATAWIDTH), .BUF_DEPTH(BUF_DEPTH)) u_buf (
    .clk     (clk),
    .n_rst   (n_rst),
    .wr_i    (buf_wr & ~in_replay),
    .clr_i   (buf_clr & ~in_replay),
    .wdata_i (buf_wdata),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d = state_q;
    pending_d = pending_q;
    len_d = len_q;
    rd_ptr_d = rd_ptr_q;
    out_valid = 1'b0;
    out_data = '0;
    out_sop = 1'b0;
    out_eop = 1'b0;
    mac_ready = 1'b0;
    last = rd_ptr_q == len_q - LENW'(1);
    case (state_q)
      IDLE: begin
        state_d = pending_q ? REPLAY : (live_en && mac_valid && mac_sop) ? LIVE : IDLE;
        // Only mid-packet strays are swallowed here; a sop word waits for LIVE.
        // n_rst keeps the sink quiet while reset is held.
        mac_ready = n_rst && live_en && !pending_q && !(mac_valid && mac_sop);
      end
      LIVE: begin
        out_valid = mac_valid;
        out_data = mac_data;
        out_sop = mac_sop;
        out_eop = mac_eop;
        mac_ready = out_ready;
        state_d = (mac_valid && out_ready && mac_eop) ? IDLE : LIVE;
      end
      REPLAY: begin
        out_valid = 1'b1;
        out_data = rdata;
        out_sop = rd_ptr_q == '0;
        out_eop = last;
        rd_ptr_d = out_ready ? (last ? '0 : rd_ptr_q + LENW'(1)) : rd_ptr_q;
        pending_d = !(out_ready && last);
        state_d = (out_ready && last) ? IDLE : REPLAY;
      end
      default: state_d = IDLE;
    endcase
    if (replay_start && replay_len != '0 && !pending_q && !in_replay) begin
      pending_d = 1'b1;
      len_d = replay_len > LENW'(BUF_DEPTH) ? LENW'(BUF_DEPTH) : replay_len;
    end
    done_d = in_replay && out_ready && last;
    drop_d = (state_q == IDLE && mac_ready && mac_valid && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    wr_err_d = wr_err_q | (in_replay & (buf_wr | buf_clr));
  end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q <= IDLE;
      pending_q <= 1'b0;
      len_q <= '0;
      rd_ptr_q <= '0;
      drop_q <= '0;
      wr_err_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      len_q <= len_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q <= drop_d;
      wr_err_q <= wr_err_d;
      done_q <= done_d;
    end

  assign busy = state_q != IDLE || pending_q;
  assign replay_done = done_q;
  assign wr_err = wr_err_q;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_sniff_feed_arbiter.sv
// tb_sniff_feed_arbiter: randomized self-checking bench with an expected-word queue model
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end end

module tb_sniff_feed_arbiter;
  localparam int DW = 32, BD = 64, LW = 7;

  logic clk = 1'b0, n_rst = 1'b1;
  logic live_en = 1'b0, buf_clr = 1'b0, buf_wr = 1'b0, replay_start = 1'b0;
  logic mac_valid = 1'b0, mac_sop = 1'b0, mac_eop = 1'b0, out_ready = 1'b1;
  logic [DW-1:0] buf_wdata = '0, mac_data = '0;
  logic [LW-1:0] replay_len = '0;
  logic mac_ready, out_valid, out_sop, out_eop, busy, replay_done, wr_err;
  logic [DW-1:0] out_data;
  logic [15:0] drop_cnt;

  typedef struct {logic [DW-1:0] d; logic s; logic e; logic rp;} word_t;
  word_t q[$];
  logic [DW-1:0] bm [BD];
  int wp = 0, checks = 0, errors = 0, rdy_mode = 0;
  logic acc = 1'b0, exp_done = 1'b0;
  logic [15:0] exp_drop = '0;

  sniff_feed_arbiter dut (
    .clk(clk), .n_rst(n_rst), .live_en(live_en), .buf_clr(buf_clr), .buf_wr(buf_wr),
    .buf_wdata(buf_wdata), .replay_start(replay_start), .replay_len(replay_len),
    .mac_data(mac_data), .mac_valid(mac_valid), .mac_sop(mac_sop), .mac_eop(mac_eop),
    .mac_ready(mac_ready), .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop),
    .out_eop(out_eop), .out_ready(out_ready), .busy(busy), .replay_done(replay_done),
    .wr_err(wr_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic fail(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    errors++;
    $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  always @(negedge clk)
    if (!n_rst) begin
      checks++;
      if (out_valid !== 1'b0 || mac_ready !== 1'b0) fail("rst_quiet", {out_valid, mac_ready}, 0);
    end

  task automatic tick();
    @(negedge clk);
    acc = n_rst && mac_valid && mac_ready;
    checks++;
    if (replay_done !== exp_done) fail("replay_done", replay_done, exp_done);
    exp_done = 1'b0;
    if (q.size() == 0) begin
      checks++;
      if (out_valid !== 1'b0) fail("no_output", out_valid, 1'b0);
    end
    else if (out_valid) begin
      checks += 3;
      if (out_data !== q[0].d) fail("out_data", out_data, q[0].d);
      if (out_sop !== q[0].s) fail("out_sop", out_sop, q[0].s);
      if (out_eop !== q[0].e) fail("out_eop", out_eop, q[0].e);
      if (q[0].rp) begin
        checks++;
        if (mac_ready !== 1'b0) fail("replay_mac_ready", mac_ready, 1'b0);
      end
      if (out_ready && n_rst) begin
        exp_done = q[0].rp && q[0].e;
        void'(q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else if (rdy_mode == 2) out_ready = ~out_ready;
  endtask

  task automatic push_replay(int len);
    int n = len > BD ? BD : len;
    for (int i = 0; i < n; i++) q.push_back('{bm[i], i == 0, i == n - 1, 1'b1});
  endtask

  task automatic replay(int len);
    replay_start = 1'b1;
    replay_len = LW'(len);
    push_replay(len);
    tick();
    replay_start = 1'b0;
  endtask

  task automatic wr(logic [DW-1:0] d, logic clr);
    buf_wr = 1'b1;
    buf_clr = clr;
    buf_wdata = d;
    if (clr) wp = 0;
    bm[wp] = d;
    wp = (wp + 1) % BD;
    tick();
    buf_wr = 1'b0;
    buf_clr = 1'b0;
  endtask

  task automatic send_live(int n, int rs_at, int rl, int le_off);
    int k;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        mac_valid = 1'b0;
        tick();
      end
      if (i == le_off) live_en = 1'b0;
      mac_valid = 1'b1;
      mac_data = $urandom;
      mac_sop = i == 0;
      mac_eop = i == n - 1;
      q.push_back('{mac_data, mac_sop, mac_eop, 1'b0});
      if (i == rs_at) begin
        replay_start = 1'b1;
        replay_len = LW'(rl);
      end
      k = 0;
      acc = 1'b0;
      while (!acc && k < 100) begin
        tick();
        replay_start = 1'b0;
        k++;
      end
      `CHK("live_accept", acc, 1'b1)
    end
    mac_valid = 1'b0;
    mac_sop = 1'b0;
    mac_eop = 1'b0;
    live_en = 1'b1;
    if (rs_at >= 0) push_replay(rl);
  endtask

  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || busy !== 1'b0) && k < 500) begin
      tick();
      k++;
    end
    `CHK("drain", q.size(), 0)
    `CHK("busy_after", busy, 1'b0)
    tick();
  endtask

  task automatic drop(int n);
    for (int i = 0; i < n; i++) begin
      mac_valid = 1'b1;
      mac_sop = 1'b0;
      mac_eop = 1'($urandom_range(0, 1));
      mac_data = $urandom;
      tick();
      `CHK("drop_accept", acc, 1'b1)
      exp_drop++;
    end
    mac_valid = 1'b0;
    mac_eop = 1'b0;
    `CHK("drop_cnt", drop_cnt, exp_drop)
  endtask

  initial begin
    int k, nw;
    live_en = 1'b1;
    mac_valid = 1'b1;
    #1 n_rst = 1'b0;
    #11;
    `CHK("rst_out_valid", out_valid, 1'b0)
    `CHK("rst_mac_ready", mac_ready, 1'b0)
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_done", replay_done, 1'b0)
    `CHK("rst_wr_err", wr_err, 1'b0)
    `CHK("rst_drop_cnt", drop_cnt, 16'd0)
    `CHK("rst_out_data", out_data, 32'd0)
    mac_valid = 1'b0;
    live_en = 1'b0;
    @(posedge clk);
    #1 n_rst = 1'b1;
    tick();
    mac_valid = 1'b1;
    tick();
    `CHK("live_off_no_accept", acc, 1'b0)
    mac_sop = 1'b1;
    tick();
    `CHK("live_off_sop_ignored", acc, 1'b0)
    `CHK("live_off_drop_cnt", drop_cnt, 16'd0)
    mac_valid = 1'b0;
    mac_sop = 1'b0;
    tick();
    wr($urandom, 1'b0);
    wr($urandom, 1'b0);
    wr($urandom, 1'b0);
    replay(3);
    repeat (4) tick();
    `CHK("back_to_back", q.size(), 0)
    tick();
    `CHK("abc_busy", busy, 1'b0)
    live_en = 1'b1;
    send_live(4, 1, 3, 99);
    drain();
    out_ready = 1'b1;
    rdy_mode = 2;
    replay(3);
    drain();
    rdy_mode = 0;
    out_ready = 1'b1;
    drop(2);
    `CHK("drop_two", drop_cnt, 16'd2)
    send_live(3, -1, 0, 1);
    drain();
    wr($urandom, 1'b0);
    out_ready = 1'b0;
    replay(4);
    tick();
    buf_wr = 1'b1;
    buf_wdata = ~bm[0];
    tick();
    buf_wr = 1'b0;
    buf_clr = 1'b1;
    tick();
    buf_clr = 1'b0;
    `CHK("wr_err_set", wr_err, 1'b1)
    out_ready = 1'b1;
    drain();
    wr($urandom, 1'b0);
    replay(5);
    drain();
    `CHK("wr_err_sticky", wr_err, 1'b1)
    replay_start = 1'b1;
    replay_len = '0;
    tick();
    replay_start = 1'b0;
    `CHK("len0_busy", busy, 1'b0)
    tick();
    `CHK("len0_busy_later", busy, 1'b0)
    for (int i = 0; i < 66; i++) wr($urandom, 1'b0);
    rdy_mode = 1;
    replay(100);
    drain();
    rdy_mode = 0;
    out_ready = 1'b1;
    wr($urandom, 1'b1);
    replay(1);
    drain();
    for (int it = 0; it < 16; it++) begin
      rdy_mode = 1;
      case ($urandom_range(0, 3))
        0: begin
          nw = $urandom_range(1, 5);
          for (int j = 0; j < nw; j++) wr($urandom, 1'($urandom_range(0, 1)) & (j == 0));
        end
        1: begin
          replay($urandom_range(1, 70));
          drain();
        end
        2: begin
          send_live($urandom_range(1, 5), -1, 0, $urandom_range(1, 6));
          drain();
        end
        default: begin
          rdy_mode = 0;
          drop($urandom_range(1, 3));
        end
      endcase
    end
    rdy_mode = 0;
    out_ready = 1'b1;
    drain();
    replay(4);
    k = 0;
    while (q.size() > 3 && k < 20) begin
      tick();
      k++;
    end
    n_rst = 1'b0;
    #1;
    `CHK("mid_rst_out_valid", out_valid, 1'b0)
    `CHK("mid_rst_sop", out_sop, 1'b0)
    `CHK("mid_rst_eop", out_eop, 1'b0)
    `CHK("mid_rst_busy", busy, 1'b0)
    `CHK("mid_rst_mac_ready", mac_ready, 1'b0)
    `CHK("mid_rst_wr_err", wr_err, 1'b0)
    `CHK("mid_rst_drop_cnt", drop_cnt, 16'd0)
    q.delete();
    exp_done = 1'b0;
    exp_drop = '0;
    wp = 0;
    tick();
    n_rst = 1'b1;
    tick();
    `CHK("post_rst_busy", busy, 1'b0)
    wr($urandom, 1'b0);
    replay(2);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
